ram_fifo_ctrl: RTL and testbench

Pointer and handshake controller that turns the 16x8 dual-port RAM into a synchronous FIFO. It drives the RAM's write and read ports as the initiator, tracks occupancy, and presents push/pop handshakes with full/empty status to the surrounding logic. It sits between a byte producer/consumer pair and the RAM instance.

---
 rtl/ram_fifo_ctrl_if.sv | 29 ++
 rtl/ram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake and status bundle for ram_fifo_ctrl.
// master: producer/consumer side; slave: the controller.
interface ram_fifo_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Pointer/handshake controller turning a 16x8 dual-port RAM into a FIFO.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module ram_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_fifo_ctrl_if.slave f,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pv;
  logic          full_w;
  logic          empty_w;
  logic          push_acc;
  logic          pop_acc;

  // Status is decoded from the registered count only.
  assign full_w   = (cnt == FULL_CNT);
  assign empty_w  = (cnt == '0);
  assign push_acc = f.push & ~full_w;
  assign pop_acc  = f.pop & ~empty_w;

  assign ram_wr_en   = push_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = f.push_data;
  assign ram_rd_en   = pop_acc;
  assign ram_rd_addr = rd_ptr;

  assign f.pop_data  = ram_rd_data;
  assign f.pop_valid = pv;
  assign f.full      = full_w;
  assign f.empty     = empty_w;
  assign f.count     = cnt;

  // Pointers advance on accepted transfers; wrap is natural at 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy and read-valid; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pv  <= 1'b0;
    end else begin
      pv <= pop_acc;
      unique case (1'b1)
        push_acc & ~pop_acc: cnt <= cnt + (AW+1)'(1);
        pop_acc & ~push_acc: cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf;
  logic udf;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (f.push & full_w) ovf <= 1'b1;
      if (f.pop & empty_w) udf <= 1'b1;
    end
  end

  assign f.overflow  = ovf;
  assign f.underflow = udf;
`else
  assign f.overflow  = 1'b0;
  assign f.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 16x8 RAM.
// Table vectors for boundary handshakes, directed sequences for the rest.
module tb_ram_fifo_ctrl;
`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic [7:0] mem [16];

  int checks;
  int errors;

  ram_fifo_ctrl_if #(.AW(4), .DW(8)) f ();

  ram_fifo_ctrl #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .f           (f),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       wr_en;
    logic [3:0] wa;
    logic       rd_en;
    logic [3:0] ra;
    logic [4:0] cnt;
    logic       pv;
    logic [7:0] pdata;
    logic       uf;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    f.push = 1'b0;
    f.pop  = 1'b0;
    f.push_data = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [3:0] exp_wa;
    logic [7:0] d;
    logic       wrapped;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    f.push = 1'b0;
    f.pop  = 1'b0;
    f.push_data = 8'h00;

    //        push pop din   wr wa rd ra cnt pv pdata uf
    tv[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 8'h00, 1'b0};
    tv[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 8'h00, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'h5A, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 8'h00, ERR};
    tv[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 4'd0, 5'd1, 1'b0, 8'h00, ERR};
    tv[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 4'd1, 1'b1, 4'd0, 5'd1, 1'b0, 8'h00, ERR};
    tv[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 4'd1, 5'd0, 1'b1, 8'h5A, ERR};
    tv[6] = '{1'b1, 1'b1, 8'h33, 1'b1, 4'd1, 1'b0, 4'd1, 5'd0, 1'b0, 8'h00, ERR};
    tv[7] = '{1'b1, 1'b1, 8'h44, 1'b1, 4'd2, 1'b1, 4'd1, 5'd1, 1'b0, 8'h00, ERR};
    tv[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 1'b0, 4'd2, 5'd1, 1'b1, 8'h33, ERR};

    // Reset state
    #2;
    chk("rst_empty", f.empty, 1);
    chk("rst_full", f.full, 0);
    chk("rst_count", f.count, 0);
    chk("rst_pv", f.pop_valid, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    tick();
    rst = 1'b0;
    #1;

    // Table: empty-side boundaries, no bypass, push+pop at count 1
    for (int i = 0; i < 9; i++) begin
      f.push = tv[i].push;
      f.pop  = tv[i].pop;
      f.push_data = tv[i].din;
      #1;
      chk($sformatf("v%0d_wr_en", i), ram_wr_en, tv[i].wr_en);
      chk($sformatf("v%0d_wa", i), ram_wr_addr, tv[i].wa);
      chk($sformatf("v%0d_rd_en", i), ram_rd_en, tv[i].rd_en);
      chk($sformatf("v%0d_ra", i), ram_rd_addr, tv[i].ra);
      chk($sformatf("v%0d_cnt", i), f.count, tv[i].cnt);
      chk($sformatf("v%0d_empty", i), f.empty, tv[i].cnt == 0);
      chk($sformatf("v%0d_pv", i), f.pop_valid, tv[i].pv);
      if (tv[i].pv)
        chk($sformatf("v%0d_pdata", i), f.pop_data, tv[i].pdata);
      chk($sformatf("v%0d_uf", i), f.underflow, tv[i].uf);
      tick();
    end

    // Fill 0x11..0x20, overflow attempt, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      f.push = 1'b1;
      f.push_data = 8'(8'h11 + i);
      #1;
      chk("fill_wr_en", ram_wr_en, 1);
      chk("fill_wa", ram_wr_addr, i);
      tick();
    end
    chk("fill_full", f.full, 1);
    chk("fill_count", f.count, 16);
    f.push_data = 8'hAA;
    #1;
    chk("ovf_wr_en", ram_wr_en, 0);
    tick();
    f.push = 1'b0;
    #1;
    chk("ovf_count", f.count, 16);
    chk("ovf_flag", f.overflow, ERR);
    tick();
    chk("ovf_sticky", f.overflow, ERR);
    for (int i = 0; i < 16; i++) begin
      f.push = (i == 0);
      f.push_data = 8'hBB;
      f.pop = 1'b1;
      #1;
      chk("drain_wr_en", ram_wr_en, 0);
      chk("drain_rd_en", ram_rd_en, 1);
      chk("drain_ra", ram_rd_addr, i);
      tick();
      chk("drain_pv", f.pop_valid, 1);
      chk("drain_data", f.pop_data, 8'(8'h11 + i));
      chk("drain_count", f.count, 15 - i);
    end
    f.pop = 1'b0;
    f.push = 1'b0;
    tick();
    chk("drain_empty", f.empty, 1);
    chk("drain_pv_end", f.pop_valid, 0);

    // Wrap-around with count held at 3
    do_reset();
    exp_wa = 4'd0;
    wrapped = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'(i * 7 + 3);
      f.push = 1'b1;
      f.push_data = d;
      q.push_back(d);
      tick();
      exp_wa = exp_wa + 4'd1;
    end
    for (int i = 3; i < 43; i++) begin
      d = 8'(i * 7 + 3);
      f.push = 1'b1;
      f.pop = 1'b1;
      f.push_data = d;
      #1;
      chk("wrap_wa", ram_wr_addr, exp_wa);
      if (exp_wa == 4'd0) wrapped = 1'b1;
      chk("wrap_both", {ram_wr_en, ram_rd_en}, 2'b11);
      q.push_back(d);
      tick();
      exp_wa = exp_wa + 4'd1;
      chk("wrap_count", f.count, 3);
      chk("wrap_data", f.pop_data, q.pop_front());
    end
    chk("wrap_seen", wrapped, 1);
    f.push = 1'b0;
    f.pop = 1'b0;

    // Reset while count = 7 with a pop in flight
    do_reset();
    for (int i = 0; i < 8; i++) begin
      f.push = 1'b1;
      f.push_data = 8'(8'hC0 + i);
      tick();
    end
    f.push = 1'b0;
    f.pop = 1'b1;
    tick();
    f.pop = 1'b0;
    chk("mid_pv_before", f.pop_valid, 1);
    chk("mid_cnt_before", f.count, 7);
    rst = 1'b1;
    #1;
    chk("mid_pv", f.pop_valid, 0);
    chk("mid_count", f.count, 0);
    chk("mid_wa", ram_wr_addr, 0);
    chk("mid_ra", ram_rd_addr, 0);
    tick();
    rst = 1'b0;
    f.push = 1'b1;
    f.push_data = 8'h77;
    #1;
    chk("mid_push_en", ram_wr_en, 1);
    chk("mid_push_wa", ram_wr_addr, 0);
    tick();
    f.push = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
